exu_wbu: RTL and testbench
==========================

Name: exu_wbu

Overview:
- Writeback stage directly downstream of the execute ALU.
- Accepts ALU results (result, write enable, rd) through a valid/ready handshake and arbitrates the single register-file write port between the LSU load-return path (priority) and ALU results.
- Buffers ALU results in a small in-order FIFO while the port is taken, and drives a registered register-file write.
- Preserves write ordering against younger loads to the same rd.

Parameters:
- FIFO_DEPTH, 2, ALU result buffer entries; power of 2, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO index width; the pointer carries one extra wrap bit.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  buffer can accept
- alu_reg_we_i  in  1  ALU result writes a register
- alu_reg_waddr_i  in  `REG_ADDR_WIDTH  ALU destination rd
- alu_result_i  in  `REG_DATA_WIDTH  ALU result
- lsu_valid_i  in  1  load-return write, this cycle, always accepted
- lsu_waddr_i  in  `REG_ADDR_WIDTH  load rd
- lsu_wdata_i  in  `REG_DATA_WIDTH  load data
- reg_we_o  out  1  register-file write enable (registered)
- reg_waddr_o  out  `REG_ADDR_WIDTH  register-file write address
- reg_wdata_o  out  `REG_DATA_WIDTH  register-file write data
- fifo_cnt_o  out  PTR_W+1  occupied entries
- fwd_raddr_i  in  `REG_ADDR_WIDTH  forwarding lookup address (feature only)
- fwd_hit_o  out  1  pending write to fwd_raddr_i exists
- fwd_data_o  out  `REG_DATA_WIDTH  youngest pending data for fwd_raddr_i

Behaviour:
- Reset (rst=0, async):
  - reg_we_o=0, reg_waddr_o=0, reg_wdata_o=`ZeroWord.
  - Pointers and all entry valid bits cleared; fifo_cnt_o=0.
  - In-flight entries are discarded.
- alu_ready_o = !full (combinational from the count only). There is no enqueue while full, even if a dequeue happens in the same cycle.
- ALU handshake completes when alu_valid_i && alu_ready_o.
  - If alu_reg_we_i=0 or alu_reg_waddr_i=0, nothing is stored.
  - Otherwise the result is stored as {valid=1, waddr, data}.
- Per-cycle source select for the next registered write:
  - LSU, if lsu_valid_i.
  - Else FIFO head, if not empty (dequeue).
  - Else the incoming accepted ALU result bypasses the FIFO (no enqueue).
  - Else no write.
- Latency: ALU result with FIFO empty and no LSU -> reg_we_o=1 in the next cycle. Each queued entry adds one cycle; each LSU cycle stalls the drain by one cycle.
- Dequeued head with its valid bit cleared (killed) -> dequeue advances, reg_we_o=0 that cycle.
- Ordering/kill rule: when lsu_valid_i, every stored entry with waddr==lsu_waddr_i has its valid bit cleared the same cycle.
  - Rationale: those ALU results are older than the load and must not overwrite it.
  - An ALU result arriving in the same cycle is younger than the load, so it is enqueued normally and not killed.
- Simultaneous LSU + ALU + FIFO non-empty -> LSU writes, ALU enqueues, head holds.
- lsu_valid_i with lsu_waddr_i=0 -> reg_we_o=1 to x0 is still issued; the register file ignores it.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by the extra pointer bit.
- fifo_cnt_o is the registered count and counts killed entries until they are dequeued.

Optional Feature:
- Macro: WBU_FWD_EN.
- With the macro: fwd_hit_o/fwd_data_o are combinational.
  - Search order, youngest first: valid FIFO entries, then the output register (reg_we_o && reg_waddr_o).
  - Match on waddr==fwd_raddr_i and fwd_raddr_i!=0; data comes from the youngest match.
- Without the macro: fwd_hit_o=0 and fwd_data_o=`ZeroWord constant; fwd_raddr_i is unused.

Decomposition:
- Shared defines.v already holds `REG_ADDR_WIDTH, `REG_DATA_WIDTH, `ZeroWord, `WriteEnable/`WriteDisable.
- Add `WBU_FIFO_DEPTH there as the default source.
- One sub-module, wbu_result_fifo, holds storage, pointers, valid bits, the kill-by-address port and the forwarding search.
- exu_wbu holds the arbitration and the output register.

Test Plan:
- Reset mid-drain: 2 entries queued, rst low for 1 cycle -> reg_we_o=0 immediately, fifo_cnt_o=0, alu_ready_o=1 after release.
- Bypass: empty FIFO, ALU valid rd=5 data=0x1234 -> next cycle reg_we_o=1, waddr=5, wdata=0x1234; fifo_cnt_o stays 0.
- Contention: LSU valid rd=3 data=0xAAAA together with ALU rd=7 data=0x5 -> cycle+1 writes x3=0xAAAA, cycle+2 writes x7=0x5.
- Full backpressure: LSU held 3 cycles with ALU issuing every cycle -> alu_ready_o=0 after 2 accepts; no loss; drain order preserved after LSU drops.
- Kill: queued ALU rd=9 data=0x11, then LSU rd=9 data=0x22 -> x9 written 0x22 only; the killed dequeue cycle shows reg_we_o=0.
- x0/no-write: ALU rd=0 or reg_we=0 -> handshake accepted, no write, fifo_cnt_o unchanged. With WBU_FWD_EN, queued rd=4 data=0x77 and fwd_raddr_i=4 -> fwd_hit_o=1, fwd_data_o=0x77.

Source files
------------

// File: rtl/exu_wbu_pkg.sv
//============================================================================
// exu_wbu_pkg : shared widths, defaults and entry type for the writeback stage
// Rev 1.0
//============================================================================
`default_nettype none

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef WriteEnable
`define WriteEnable 1'b1
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif
`ifndef WBU_FIFO_DEPTH
`define WBU_FIFO_DEPTH 2
`endif

package exu_wbu_pkg;
  localparam int ADDR_W         = `REG_ADDR_WIDTH;
  localparam int DATA_W         = `REG_DATA_WIDTH;
  localparam int DEF_FIFO_DEPTH = `WBU_FIFO_DEPTH;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t ZERO_WORD = `ZeroWord;

  typedef struct packed {
    addr_t waddr;
    data_t wdata;
  } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/exu_wbu_if.sv
//============================================================================
// exu_wbu_if : ALU/LSU inputs, register-file write and forwarding port bundle
// Rev 1.0
//============================================================================
`default_nettype none

interface exu_wbu_if
  import exu_wbu_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) ();
  logic             alu_valid_i;
  logic             alu_ready_o;
  logic             alu_reg_we_i;
  addr_t            alu_reg_waddr_i;
  data_t            alu_result_i;
  logic             lsu_valid_i;
  addr_t            lsu_waddr_i;
  data_t            lsu_wdata_i;
  logic             reg_we_o;
  addr_t            reg_waddr_o;
  data_t            reg_wdata_o;
  logic [PTR_W:0]   fifo_cnt_o;
  addr_t            fwd_raddr_i;
  logic             fwd_hit_o;
  data_t            fwd_data_o;

  modport mst (
    output alu_valid_i, alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i, fwd_raddr_i,
    input  alu_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o,
    input  fifo_cnt_o, fwd_hit_o, fwd_data_o
  );

  modport slv (
    input  alu_valid_i, alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i, fwd_raddr_i,
    output alu_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o,
    output fifo_cnt_o, fwd_hit_o, fwd_data_o
  );
endinterface

`default_nettype wire

// File: rtl/wbu_result_fifo.sv
//============================================================================
// wbu_result_fifo : in-order ALU result buffer with kill-by-address and
// optional forwarding search (enabled by macro WBU_FWD_EN).  Rev 1.0
//============================================================================
`default_nettype none

module wbu_result_fifo
  import exu_wbu_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           i_push,
  input  wire wb_req_t        i_push_req,
  input  wire logic           i_pop,
  input  wire logic           i_kill_en,
  input  wire addr_t          i_kill_addr,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_head_valid,
  output wb_req_t             o_head_req,
  output logic [PTR_W:0]      o_cnt,
  input  wire addr_t          i_fwd_raddr,
  input  wire logic           i_out_we,
  input  wire addr_t          i_out_addr,
  input  wire data_t          i_out_data,
  output logic                o_fwd_hit,
  output data_t               o_fwd_data
);
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic [FIFO_DEPTH-1:0] r_valid;
  wb_req_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      w_widx;
  logic [PTR_W-1:0]      w_ridx;

  assign w_widx       = r_wptr[PTR_W-1:0];
  assign w_ridx       = r_rptr[PTR_W-1:0];
  assign o_cnt        = r_wptr - r_rptr;
  assign o_full       = (o_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign o_empty      = (r_wptr == r_rptr);
  assign o_head_valid = r_valid[w_ridx];
  assign o_head_req   = r_mem[w_ridx];

  // Kill precedes push so a same-cycle (younger) entry keeps its valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_valid <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (i_kill_en && (r_mem[i].waddr == i_kill_addr)) r_valid[i] <= 1'b0;
      end
      if (i_push) begin
        r_valid[w_widx] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_widx] <= i_push_req;
  end

`ifdef WBU_FWD_EN
  // Walk oldest to youngest so the last match is the youngest pending write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    o_fwd_hit  = i_out_we && (i_out_addr == i_fwd_raddr) && (i_fwd_raddr != '0);
    o_fwd_data = o_fwd_hit ? i_out_data : ZERO_WORD;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = w_ridx + PTR_W'(i);
      if (((PTR_W+1)'(i) < o_cnt) && r_valid[idx] &&
          (r_mem[idx].waddr == i_fwd_raddr) && (i_fwd_raddr != '0)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = r_mem[idx].wdata;
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_fwd_raddr, i_out_we, i_out_addr, i_out_data};
  assign o_fwd_hit    = 1'b0;
  assign o_fwd_data   = ZERO_WORD;
`endif

endmodule

`default_nettype wire

// File: rtl/exu_wbu.sv
//============================================================================
// exu_wbu : writeback arbitration (LSU over ALU) and registered RF write port
// Rev 1.0
//============================================================================
`default_nettype none

module exu_wbu
  import exu_wbu_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  wire logic clk,
  input  wire logic rst,
  exu_wbu_if.slv    bus
);
  logic           w_full;
  logic           w_empty;
  logic           w_head_valid;
  wb_req_t        w_head_req;
  wb_req_t        w_alu_req;
  logic [PTR_W:0] w_cnt;
  logic           w_alu_wr;
  logic           w_push;
  logic           w_pop;
  logic           r_we;
  addr_t          r_waddr;
  data_t          r_wdata;

  // A handshake with no destination (we=0 or x0) is accepted and dropped.
  assign w_alu_wr  = bus.alu_valid_i && !w_full && bus.alu_reg_we_i &&
                     (bus.alu_reg_waddr_i != '0);
  assign w_alu_req = '{waddr: bus.alu_reg_waddr_i, wdata: bus.alu_result_i};
  assign w_pop     = !bus.lsu_valid_i && !w_empty;
  assign w_push    = w_alu_wr && (bus.lsu_valid_i || !w_empty);

  wbu_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_req   (w_alu_req),
    .i_pop        (w_pop),
    .i_kill_en    (bus.lsu_valid_i),
    .i_kill_addr  (bus.lsu_waddr_i),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_valid (w_head_valid),
    .o_head_req   (w_head_req),
    .o_cnt        (w_cnt),
    .i_fwd_raddr  (bus.fwd_raddr_i),
    .i_out_we     (r_we),
    .i_out_addr   (r_waddr),
    .i_out_data   (r_wdata),
    .o_fwd_hit    (bus.fwd_hit_o),
    .o_fwd_data   (bus.fwd_data_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= ZERO_WORD;
    end else if (bus.lsu_valid_i) begin
      r_we    <= 1'b1;
      r_waddr <= bus.lsu_waddr_i;
      r_wdata <= bus.lsu_wdata_i;
    end else if (!w_empty) begin
      r_we    <= w_head_valid;
      r_waddr <= w_head_req.waddr;
      r_wdata <= w_head_req.wdata;
    end else if (w_alu_wr) begin
      r_we    <= 1'b1;
      r_waddr <= w_alu_req.waddr;
      r_wdata <= w_alu_req.wdata;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign bus.alu_ready_o = !w_full;
  assign bus.reg_we_o    = r_we;
  assign bus.reg_waddr_o = r_waddr;
  assign bus.reg_wdata_o = r_wdata;
  assign bus.fifo_cnt_o  = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exu_wbu.sv
//============================================================================
// tb_exu_wbu : directed stimulus with an expected-write scoreboard for exu_wbu
// Rev 1.0
//============================================================================
`default_nettype none

module tb_exu_wbu;
  import exu_wbu_pkg::*;

  typedef struct packed {
    addr_t a;
    data_t d;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  exu_wbu_if bus ();

  exu_wbu dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input addr_t a, input data_t d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // Inputs are held across exactly one rising edge.
  task automatic drive(input logic lv, input addr_t la, input data_t ld,
                       input logic av, input logic awe, input addr_t aa, input data_t ad);
    bus.lsu_valid_i     = lv;
    bus.lsu_waddr_i     = la;
    bus.lsu_wdata_i     = ld;
    bus.alu_valid_i     = av;
    bus.alu_reg_we_i    = awe;
    bus.alu_reg_waddr_i = aa;
    bus.alu_result_i    = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      idle();
      k++;
    end
    idle();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every presented write is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.reg_we_o) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%0h expected none",
                 bus.reg_waddr_o, bus.reg_wdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.reg_waddr_o !== e.a || bus.reg_wdata_o !== e.d) begin
          n_fail++;
          $display("FAIL write_order: got x%0d=%0h expected x%0d=%0h",
                   bus.reg_waddr_o, bus.reg_wdata_o, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.fwd_raddr_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.alu_valid_i = 1'b0; bus.alu_reg_we_i = 1'b0;
    bus.alu_reg_waddr_i = '0; bus.alu_result_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    64'(bus.reg_we_o),    64'd0);
    chk("rst_waddr", 64'(bus.reg_waddr_o), 64'd0);
    chk("rst_wdata", 64'(bus.reg_wdata_o), 64'd0);
    chk("rst_cnt",   64'(bus.fifo_cnt_o),  64'd0);
    chk("rst_ready", 64'(bus.alu_ready_o), 64'd1);
    rst_n = 1'b1;
    idle();

    // Bypass: empty FIFO, no LSU
    expect_wr(5'd5, 32'h1234);
    drive(0, 0, 0, 1, 1, 5'd5, 32'h1234);
    chk("bypass_we",  64'(bus.reg_we_o),   64'd1);
    chk("bypass_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    wait_drain("bypass");

    // Contention: LSU wins, ALU queued
    expect_wr(5'd3, 32'hAAAA);
    expect_wr(5'd7, 32'h5);
    drive(1, 5'd3, 32'hAAAA, 1, 1, 5'd7, 32'h5);
    chk("contend_cnt1", 64'(bus.fifo_cnt_o), 64'd1);
    idle();
    chk("contend_cnt0", 64'(bus.fifo_cnt_o), 64'd0);
    wait_drain("contend");

    // Full backpressure: LSU for 3 cycles, ALU every cycle
    expect_wr(5'd10, 32'hA1); expect_wr(5'd11, 32'hA2); expect_wr(5'd12, 32'hA3);
    expect_wr(5'd13, 32'hB1); expect_wr(5'd14, 32'hB2); expect_wr(5'd15, 32'hB3);
    chk("bp_ready_c1", 64'(bus.alu_ready_o), 64'd1);
    drive(1, 5'd10, 32'hA1, 1, 1, 5'd13, 32'hB1);
    chk("bp_ready_c2", 64'(bus.alu_ready_o), 64'd1);
    drive(1, 5'd11, 32'hA2, 1, 1, 5'd14, 32'hB2);
    chk("bp_cnt_full", 64'(bus.fifo_cnt_o), 64'd2);
    chk("bp_ready_c3", 64'(bus.alu_ready_o), 64'd0);
    drive(1, 5'd12, 32'hA3, 1, 1, 5'd15, 32'hB3);
    chk("bp_ready_c4", 64'(bus.alu_ready_o), 64'd0);
    drive(0, 0, 0, 1, 1, 5'd15, 32'hB3);
    chk("bp_ready_c5", 64'(bus.alu_ready_o), 64'd1);
    drive(0, 0, 0, 1, 1, 5'd15, 32'hB3);
    chk("bp_cnt_c5", 64'(bus.fifo_cnt_o), 64'd1);
    wait_drain("backpressure");

    // Kill: queued x9 is overtaken by a load to x9
    expect_wr(5'd2, 32'h33);
    expect_wr(5'd9, 32'h22);
    drive(1, 5'd2, 32'h33, 1, 1, 5'd9, 32'h11);
    drive(1, 5'd9, 32'h22, 0, 0, 0, 0);
    chk("kill_cnt_held", 64'(bus.fifo_cnt_o), 64'd1);
    idle();
    chk("kill_dequeue_we", 64'(bus.reg_we_o),   64'd0);
    chk("kill_cnt_zero",   64'(bus.fifo_cnt_o), 64'd0);
    wait_drain("kill");

    // Same-cycle ALU to the load's rd is younger and survives
    expect_wr(5'd6, 32'h60);
    expect_wr(5'd6, 32'h61);
    drive(1, 5'd6, 32'h60, 1, 1, 5'd6, 32'h61);
    wait_drain("same_rd");

    // x0 / no-write ALU results; LSU to x0 still writes
    chk("x0_ready", 64'(bus.alu_ready_o), 64'd1);
    drive(0, 0, 0, 1, 1, 5'd0, 32'h99);
    chk("x0_we",  64'(bus.reg_we_o),   64'd0);
    chk("x0_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    drive(0, 0, 0, 1, 0, 5'd8, 32'h98);
    chk("nowe_we",  64'(bus.reg_we_o),   64'd0);
    expect_wr(5'd0, 32'h55);
    drive(1, 5'd0, 32'h55, 1, 1, 5'd0, 32'h97);
    chk("lsu_x0_we",  64'(bus.reg_we_o),   64'd1);
    chk("lsu_x0_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    wait_drain("x0");

    // Forwarding
    expect_wr(5'd3, 32'h1);
    expect_wr(5'd4, 32'h77);
    drive(1, 5'd3, 32'h1, 1, 1, 5'd4, 32'h77);
    bus.fwd_raddr_i = 5'd4;
    #1;
`ifdef WBU_FWD_EN
    chk("fwd_fifo_hit",  64'(bus.fwd_hit_o),  64'd1);
    chk("fwd_fifo_data", 64'(bus.fwd_data_o), 64'h77);
    bus.fwd_raddr_i = 5'd3;
    #1;
    chk("fwd_reg_hit",  64'(bus.fwd_hit_o),  64'd1);
    chk("fwd_reg_data", 64'(bus.fwd_data_o), 64'h1);
`else
    chk("fwd_off_hit",  64'(bus.fwd_hit_o),  64'd0);
    chk("fwd_off_data", 64'(bus.fwd_data_o), 64'd0);
`endif
    bus.fwd_raddr_i = '0;
    wait_drain("fwd");

    // Reset mid-drain with two entries queued
    expect_wr(5'd1, 32'h1);
    expect_wr(5'd2, 32'h2);
    drive(1, 5'd1, 32'h1, 1, 1, 5'd20, 32'hC1);
    drive(1, 5'd2, 32'h2, 1, 1, 5'd21, 32'hC2);
    chk("mid_cnt2", 64'(bus.fifo_cnt_o), 64'd2);
    bus.lsu_valid_i = 1'b0;
    bus.alu_valid_i = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",  64'(bus.reg_we_o),   64'd0);
    chk("mid_rst_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rel_ready", 64'(bus.alu_ready_o), 64'd1);
    chk("mid_rel_cnt",   64'(bus.fifo_cnt_o),  64'd0);
    repeat (4) idle();
    wait_drain("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
